// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared FSM states, byte-index type and word geometry for the instruction-memory loader
package im_loader_pkg;
    localparam int BYTES_PER_WORD = 4;
    typedef logic [$clog2(BYTES_PER_WORD)-1:0] byte_idx_t;
`ifdef IM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CSUM, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;
`endif
endpackage

// File: rtl/im_loader_packer.sv
// im_loader_packer: places incoming bytes little-endian into a zero-padded word register
module im_loader_packer
    import im_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        full
);
    byte_idx_t   idx;
    logic [31:0] placed;
    assign full = idx == byte_idx_t'(BYTES_PER_WORD - 1);
    // current word with the incoming byte dropped into its lane
    always_comb begin
        placed = word;
        placed[8*idx +: 8] = data;
    end
    // clearing restarts at lane 0 with an all-zero word so short final words come out padded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            idx  <= '0;
        end else if (clear) begin
            word <= '0;
            idx  <= '0;
        end else if (accept) begin
            word <= placed;
            idx  <= idx + byte_idx_t'(1);
        end
    end
endmodule

// File: rtl/im_loader.sv
// im_loader: packs a byte stream into words, writes instruction memory, releases core reset when loaded (optional IM_LOADER_CHECKSUM_EN)
module im_loader
    import im_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           start_i,
    input  logic                           s_valid_i,
    input  logic [7:0]                     s_data_i,
    input  logic                           s_last_i,
    output logic                           s_ready_o,
    output logic                           mem_wen_o,
    output logic [31:0]                    mem_addr_o,
    output logic [31:0]                    mem_din_o,
    output logic                           core_rst_n_o,
    output logic                           done_o,
    output logic                           error_o,
    output logic [$clog2(MAX_WORDS+1)-1:0] word_count_o
);
    localparam int CW = $clog2(MAX_WORDS + 1);
    state_t      state, next;
    logic [31:0] addr, word;
    logic        full, last_q, acc, start_ok, overflow, pk_accept;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [31:0] sum;
    assign s_ready_o = state == RECV || state == CSUM;
`else
    assign s_ready_o = state == RECV;
`endif
    assign acc          = s_valid_i && s_ready_o;
    assign start_ok     = start_i && (state == IDLE || state == DONE || state == ERR);
    assign overflow     = word_count_o == CW'(MAX_WORDS);
    assign pk_accept    = acc && !(state == RECV && overflow);
    assign mem_wen_o    = state == WRITE;
    assign mem_addr_o   = mem_wen_o ? addr : '0;
    assign mem_din_o    = mem_wen_o ? word : '0;
    assign core_rst_n_o = state == DONE;
    assign done_o       = state == DONE;
    assign error_o      = state == ERR;
    im_loader_packer u_packer (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .clear  (start_ok || state == WRITE),
        .accept (pk_accept),
        .data   (s_data_i),
        .word   (word),
        .full   (full)
    );
    // state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= next;
    end
    // next-state: a byte arriving with the image already at capacity is dropped and faults the load
    always_comb begin
        next = state;
        unique case (state)
            IDLE, DONE, ERR: if (start_i) next = RECV;
            RECV:            if (acc) next = overflow ? ERR : (full || s_last_i) ? WRITE : RECV;
`ifdef IM_LOADER_CHECKSUM_EN
            WRITE:           next = last_q ? CSUM : RECV;
            CSUM:            if (acc && full) next = {s_data_i, word[23:0]} == sum ? DONE : ERR;
`else
            WRITE:           next = last_q ? DONE : RECV;
`endif
            default:         next = IDLE;
        endcase
    end
    // write address, word counter and the end-of-image marker carried into WRITE
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr         <= '0;
            word_count_o <= '0;
            last_q       <= 1'b0;
        end else if (start_ok) begin
            addr         <= BASE_ADDR;
            word_count_o <= '0;
            last_q       <= 1'b0;
        end else if (state == WRITE) begin
            addr         <= addr + ADDR_STEP;
            word_count_o <= word_count_o + 1'b1;
        end else if (state == RECV && acc && !overflow) begin
            last_q       <= s_last_i;
        end
    end
`ifdef IM_LOADER_CHECKSUM_EN
    // running wrap-around sum of every word written, padded value included
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)            sum <= '0;
        else if (start_ok)       sum <= '0;
        else if (state == WRITE) sum <= sum + word;
    end
`endif
endmodule
